bip_run_controller: RTL and testbench

- Sequencer that owns one BIP processor run: streams a program into instruction memory, holds the CPU in reset, releases it, then watches the fetched instructions.
- Ends the run on HLT, cycle-limit timeout or out-of-range fetch, and reports status and counts.
- Sits between the host/bench and the BIP2 core plus instruction_memory, replacing hand-timed reset and stimulus sequences.

---
 rtl/bip_run_controller_if.sv | 28 ++
 rtl/bip_run_controller.sv | 209 ++++++++++++++++++++
 tb/tb_bip_run_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_run_controller_if.sv
// Load-stream interface between the host (program source) and the run controller.
//   load_valid_in  : host has a program word on load_data_in
//   load_ready_out : controller accepts the word this cycle
//   load_data_in   : program word
//   load_last_in   : word is the final one of the program
// The host side uses the master modport, the controller the slave modport.
interface bip_run_controller_if #(
    parameter int INSTRUCTION_DATA_WIDTH = 16
);
    logic                              load_valid_in;
    logic                              load_ready_out;
    logic [INSTRUCTION_DATA_WIDTH-1:0] load_data_in;
    logic                              load_last_in;

    modport master (
        output load_valid_in,
        output load_data_in,
        output load_last_in,
        input  load_ready_out
    );

    modport slave (
        input  load_valid_in,
        input  load_data_in,
        input  load_last_in,
        output load_ready_out
    );
endinterface

// File: rtl/bip_run_controller.sv
// Sequencer for one BIP processor run: streams a program into instruction
// memory, holds the CPU in reset, releases it and watches the fetch stream
// until HLT, a cycle-limit timeout or an out-of-range fetch ends the run.
// Ports:
//   clock_in, reset_in            : clock, synchronous active-high reset
//   start_in                      : one-cycle pulse, starts a load (IDLE/END only)
//   load_bus (slave)              : program word stream with valid/ready/last
//   prog_wr/address/data_out      : instruction memory write port (1-cycle latency)
//   cpu_reset_out                 : CPU reset, polarity set by CPU_RESET_ACTIVE_HIGH
//   instruction_in/_address_in    : current CPU fetch
//   cycle_limit_in                : run cycle limit, 0 = unlimited
//   busy/done/timeout/range_error : status; the three end flags are sticky
//   cycle_count_out               : RUN cycles elapsed (saturating)
//   program_length_out            : number of words loaded
module bip_run_controller #(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16,
    parameter int OPCODE_WIDTH           = 5,
    parameter int HLT_OPCODE             = 0,
    parameter int RESET_CYCLES           = 2,
    parameter int CYCLE_WIDTH            = 24,
    parameter int CPU_RESET_ACTIVE_HIGH  = 1
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    input  logic                              start_in,
    bip_run_controller_if.slave               load_bus,
    output logic                              prog_wr_out,
    output logic [OPERAND_ADDRESS_WIDTH-1:0]  prog_address_out,
    output logic [INSTRUCTION_DATA_WIDTH-1:0] prog_data_out,
    output logic                              cpu_reset_out,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] instruction_in,
    input  logic [OPERAND_ADDRESS_WIDTH-1:0]  instruction_address_in,
    input  logic [CYCLE_WIDTH-1:0]            cycle_limit_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              timeout_out,
    output logic                              range_error_out,
    output logic [CYCLE_WIDTH-1:0]            cycle_count_out,
    output logic [OPERAND_ADDRESS_WIDTH:0]    program_length_out
);
    localparam int AW = OPERAND_ADDRESS_WIDTH;
    localparam int DW = INSTRUCTION_DATA_WIDTH;
    localparam int CW = CYCLE_WIDTH;
    // Hold counter runs RESET_CYCLES-1 down to 0.
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [HW-1:0]           HOLD_LOAD    = HW'(RESET_CYCLES - 1);
    localparam logic [HW-1:0]           HOLD_ONE     = HW'(1);
    localparam logic [AW-1:0]           ADDR_ONE     = AW'(1);
    localparam logic [AW-1:0]           ADDR_LAST    = '1;
    localparam logic [AW:0]             LEN_ONE      = (AW + 1)'(1);
    localparam logic [CW-1:0]           CNT_ONE      = CW'(1);
    localparam logic [CW-1:0]           CNT_MAX      = '1;
    localparam logic [OPCODE_WIDTH-1:0] HLT_OP       = OPCODE_WIDTH'(HLT_OPCODE);
    localparam logic                    CPU_RESET_ON = (CPU_RESET_ACTIVE_HIGH != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_END
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_addr_reg, wr_addr_next;
    logic [AW:0]     length_reg, length_next;
    logic [HW-1:0]   hold_reg, hold_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            prog_wr_reg, prog_wr_next;
    logic [AW-1:0]   prog_address_reg, prog_address_next;
    logic [DW-1:0]   prog_data_reg, prog_data_next;
    logic            load_ready_reg, load_ready_next;
    logic            cpu_reset_reg, cpu_reset_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            timeout_reg, timeout_next;
    logic            range_reg, range_next;

    logic            beat;
    logic            hit_hlt;
    logic            hit_range;
    logic            hit_limit;

    always_comb begin
        state_next        = state_reg;
        wr_addr_next      = wr_addr_reg;
        length_next       = length_reg;
        hold_next         = hold_reg;
        count_next        = count_reg;
        prog_wr_next      = 1'b0;
        prog_address_next = prog_address_reg;
        prog_data_next    = prog_data_reg;
        done_next         = done_reg;
        timeout_next      = timeout_reg;
        range_next        = range_reg;

        // load_ready_reg is only ever high in LOAD, so valid outside LOAD is ignored.
        beat      = load_bus.load_valid_in && load_ready_reg;
        hit_hlt   = (instruction_in[DW-1 -: OPCODE_WIDTH] == HLT_OP);
        hit_range = ({1'b0, instruction_address_in} >= length_reg);
        hit_limit = (cycle_limit_in != '0) && (count_reg == cycle_limit_in);

        case (state_reg)
            ST_IDLE, ST_END: begin
                if (start_in) begin
                    state_next   = ST_LOAD;
                    wr_addr_next = '0;
                    length_next  = '0;
                    count_next   = '0;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    range_next   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    prog_wr_next      = 1'b1;
                    prog_address_next = wr_addr_reg;
                    prog_data_next    = load_bus.load_data_in;
                    wr_addr_next      = wr_addr_reg + ADDR_ONE;
                    length_next       = length_reg + LEN_ONE;
                    // The top address is an implicit last word: the program never wraps.
                    if (load_bus.load_last_in || (wr_addr_reg == ADDR_LAST)) begin
                        state_next = ST_HOLD;
                        hold_next  = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    hold_next = hold_reg - HOLD_ONE;
                end
            end
            ST_RUN: begin
                // HLT beats range error beats timeout; only one flag is ever set.
                if (hit_hlt) begin
                    done_next  = 1'b1;
                    state_next = ST_END;
                end else if (hit_range) begin
                    range_next = 1'b1;
                    state_next = ST_END;
                end else if (hit_limit) begin
                    timeout_next = 1'b1;
                    state_next   = ST_END;
                end else if (count_reg != CNT_MAX) begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Output registers are loaded from the state being entered so every
        // output lines up with the state it describes.
        load_ready_next = (state_next == ST_LOAD);
        busy_next       = (state_next == ST_LOAD) || (state_next == ST_HOLD) ||
                          (state_next == ST_RUN);
        cpu_reset_next  = (state_next == ST_RUN) ? ~CPU_RESET_ON : CPU_RESET_ON;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_reg        <= ST_IDLE;
            wr_addr_reg      <= '0;
            length_reg       <= '0;
            hold_reg         <= '0;
            count_reg        <= '0;
            prog_wr_reg      <= 1'b0;
            prog_address_reg <= '0;
            prog_data_reg    <= '0;
            load_ready_reg   <= 1'b0;
            cpu_reset_reg    <= CPU_RESET_ON;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
            range_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wr_addr_reg      <= wr_addr_next;
            length_reg       <= length_next;
            hold_reg         <= hold_next;
            count_reg        <= count_next;
            prog_wr_reg      <= prog_wr_next;
            prog_address_reg <= prog_address_next;
            prog_data_reg    <= prog_data_next;
            load_ready_reg   <= load_ready_next;
            cpu_reset_reg    <= cpu_reset_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            timeout_reg      <= timeout_next;
            range_reg        <= range_next;
        end
    end

    assign load_bus.load_ready_out = load_ready_reg;
    assign prog_wr_out             = prog_wr_reg;
    assign prog_address_out        = prog_address_reg;
    assign prog_data_out           = prog_data_reg;
    assign cpu_reset_out           = cpu_reset_reg;
    assign busy_out                = busy_reg;
    assign done_out                = done_reg;
    assign timeout_out             = timeout_reg;
    assign range_error_out         = range_reg;
    assign cycle_count_out         = count_reg;
    assign program_length_out      = length_reg;
endmodule

// File: tb/tb_bip_run_controller.sv
// Scoreboard bench for bip_run_controller (3-bit address space, 8-word depth).
// The load driver pushes expected memory writes; the run tasks push expected
// end-of-run status. Independent monitors pop and compare when the DUT shows
// a write or leaves its busy states.
module tb_bip_run_controller;
    localparam int W  = 3;
    localparam int D  = 16;
    localparam int CW = 24;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          start_in = 1'b0;
    logic          prog_wr_out;
    logic [W-1:0]  prog_address_out;
    logic [D-1:0]  prog_data_out;
    logic          cpu_reset_out;
    logic [D-1:0]  instruction_in;
    logic [W-1:0]  instruction_address_in;
    logic [CW-1:0] cycle_limit_in = '0;
    logic          busy_out, done_out, timeout_out, range_error_out;
    logic [CW-1:0] cycle_count_out;
    logic [W:0]    program_length_out;

    bip_run_controller_if #(.INSTRUCTION_DATA_WIDTH(D)) load_bus ();

    bip_run_controller #(
        .OPERAND_ADDRESS_WIDTH(W), .INSTRUCTION_DATA_WIDTH(D), .OPCODE_WIDTH(5),
        .HLT_OPCODE(0), .RESET_CYCLES(RC), .CYCLE_WIDTH(CW), .CPU_RESET_ACTIVE_HIGH(1)
    ) dut (
        .clock_in(clk), .reset_in(reset_in), .start_in(start_in), .load_bus(load_bus),
        .prog_wr_out(prog_wr_out), .prog_address_out(prog_address_out),
        .prog_data_out(prog_data_out), .cpu_reset_out(cpu_reset_out),
        .instruction_in(instruction_in), .instruction_address_in(instruction_address_in),
        .cycle_limit_in(cycle_limit_in), .busy_out(busy_out), .done_out(done_out),
        .timeout_out(timeout_out), .range_error_out(range_error_out),
        .cycle_count_out(cycle_count_out), .program_length_out(program_length_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [D-1:0] d;
    } wr_t;

    typedef struct packed {
        logic          done;
        logic          to;
        logic          re;
        logic [CW-1:0] cnt;
        logic [W:0]    len;
    } end_t;

    wr_t  wr_q[$];
    end_t end_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Simple CPU stand-in: fetch pointer held at 0 in reset, then steps by one,
    // optionally looping back to 0 after loop_len words.
    logic [W-1:0] pc = '0;
    logic [D-1:0] bmem [8];
    int           loop_len = 0;
    logic [D-1:0] pw [8];

    always @(posedge clk) begin
        if (cpu_reset_out) pc <= '0;
        else if (loop_len != 0 && int'(pc) == loop_len - 1) pc <= '0;
        else pc <= pc + 3'd1;
    end
    assign instruction_address_in = pc;
    assign instruction_in         = bmem[pc];

    // Write monitor: every accepted beat must appear as a write on the next edge.
    always @(posedge clk) begin
        #1;
        if (prog_wr_out) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_write actual=addr %0d required=no write", prog_address_out);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(prog_address_out), 32'(e.a));
                check("wr_data", 32'(prog_data_out), 32'(e.d));
            end
        end else if (wr_q.size() != 0) begin
            total++; bad++;
            $display("FAIL wr_latency actual=no write required=addr %0d", wr_q[0].a);
            wr_q.delete(0);
        end
    end

    // End monitor: compare status when the controller drops busy.
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (busy_prev && !busy_out) begin
            if (end_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_end actual=busy fell required=no end");
            end else begin
                end_t e;
                e = end_q.pop_front();
                check("done", 32'(done_out), 32'(e.done));
                check("timeout", 32'(timeout_out), 32'(e.to));
                check("range_error", 32'(range_error_out), 32'(e.re));
                check("cycle_count", 32'(cycle_count_out), 32'(e.cnt));
                check("program_length", 32'(program_length_out), 32'(e.len));
                check("end_cpu_reset", 32'(cpu_reset_out), 32'd1);
                check("end_load_ready", 32'(load_bus.load_ready_out), 32'd0);
            end
        end
        busy_prev <= busy_out;
    end

    // Hold monitor: count reset cycles between the end of LOAD and the release.
    int   hold_cnt = 0;
    logic cpu_reset_prev = 1'b1;
    always @(posedge clk) begin
        #1;
        if (load_bus.load_ready_out) hold_cnt <= 0;
        else if (busy_out && cpu_reset_out) hold_cnt <= hold_cnt + 1;
        if (busy_out && !cpu_reset_out && cpu_reset_prev)
            check("hold_cycles", 32'(hold_cnt), 32'(RC));
        cpu_reset_prev <= cpu_reset_out;
    end

    function automatic end_t mk_end(input logic dn, input logic to, input logic re,
                                    input int cnt, input int len);
        end_t e;
        e.done = dn; e.to = to; e.re = re;
        e.cnt  = CW'(cnt);
        e.len  = (W + 1)'(len);
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
    endtask

    // Streams pw[0..n-1]; toggle alternates valid each cycle; start_at pulses
    // start_in on that driver cycle (0 = never).
    task automatic load_prog(input int n, input bit use_last, input bit toggle, input int start_at);
        int idx = 0;
        int guard = 0;
        bit phase = 1'b0;
        for (int i = 0; i < 8; i++) bmem[i] = 16'hF800;
        while (idx < n && guard < 100) begin
            @(negedge clk);
            guard++;
            start_in = (guard == start_at);
            load_bus.load_valid_in = toggle ? phase : 1'b1;
            phase = ~phase;
            load_bus.load_data_in = pw[idx];
            load_bus.load_last_in = use_last && (idx == n - 1);
            if (load_bus.load_valid_in && load_bus.load_ready_out) begin
                wr_t e;
                e.a = idx[W-1:0];
                e.d = pw[idx];
                wr_q.push_back(e);
                bmem[idx] = pw[idx];
                idx++;
            end
        end
        @(negedge clk);
        load_bus.load_valid_in = 1'b0;
        load_bus.load_last_in  = 1'b0;
        start_in = 1'b0;
        if (idx < n) begin
            total++; bad++;
            $display("FAIL load_timeout actual=%0d words required=%0d", idx, n);
        end
    endtask

    task automatic wait_end();
        int g = 0;
        while (end_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (end_q.size() != 0) begin
            total++; bad++;
            $display("FAIL run_timeout actual=still busy required=run ended");
            end_q.delete();
        end
    endtask

    task automatic run_test(input int n, input bit use_last, input bit toggle, input int start_at,
                            input int limit, input int lp, input end_t exp);
        cycle_limit_in = CW'(limit);
        loop_len = lp;
        end_q.push_back(exp);
        pulse_start();
        load_prog(n, use_last, toggle, start_at);
        wait_end();
    endtask

    initial begin
        load_bus.load_valid_in = 1'b0;
        load_bus.load_data_in  = '0;
        load_bus.load_last_in  = 1'b0;
        for (int i = 0; i < 8; i++) bmem[i] = 16'hF800;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset_out), 32'd1);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_timeout", 32'(timeout_out), 32'd0);
        check("rst_range", 32'(range_error_out), 32'd0);
        check("rst_count", 32'(cycle_count_out), 32'd0);
        check("rst_length", 32'(program_length_out), 32'd0);
        check("rst_prog_wr", 32'(prog_wr_out), 32'd0);
        check("rst_ready", 32'(load_bus.load_ready_out), 32'd0);
        reset_in = 1'b0;

        // Three words, HLT at address 2 -> done at count 2.
        pw[0] = 16'h0801; pw[1] = 16'h1802; pw[2] = 16'h0000;
        run_test(3, 1'b1, 1'b0, 0, 0, 0, mk_end(1'b1, 1'b0, 1'b0, 2, 3));

        // Looping program without HLT, limit 10 -> timeout at count 10.
        pw[0] = 16'h0801; pw[1] = 16'h1802; pw[2] = 16'h2003;
        run_test(3, 1'b1, 1'b0, 0, 10, 3, mk_end(1'b0, 1'b1, 1'b0, 10, 3));

        // Two words, no HLT, fetch walks to address 2 -> range error.
        pw[0] = 16'h0801; pw[1] = 16'h1802;
        run_test(2, 1'b1, 1'b0, 0, 0, 0, mk_end(1'b0, 1'b0, 1'b1, 2, 2));

        // HLT fetched at count 3 with limit 3 -> HLT wins.
        pw[0] = 16'h0801; pw[1] = 16'h1802; pw[2] = 16'h2003; pw[3] = 16'h0000;
        run_test(4, 1'b1, 1'b0, 0, 3, 0, mk_end(1'b1, 1'b0, 1'b0, 3, 4));

        // Toggling valid, eight words, no last; start mid-load is ignored.
        pw[0] = 16'h0801; pw[1] = 16'h1802; pw[2] = 16'h2003; pw[3] = 16'h2804;
        pw[4] = 16'h3005; pw[5] = 16'h3806; pw[6] = 16'h4007; pw[7] = 16'h4808;
        run_test(8, 1'b0, 1'b1, 5, 4, 0, mk_end(1'b0, 1'b1, 1'b0, 4, 8));

        // Reset during RUN at cycle count 5 -> everything back to reset values.
        pw[0] = 16'h0801; pw[1] = 16'h1802; pw[2] = 16'h2003;
        cycle_limit_in = '0;
        loop_len = 3;
        end_q.push_back(mk_end(1'b0, 1'b0, 1'b0, 0, 0));
        pulse_start();
        load_prog(3, 1'b1, 1'b0, 0);
        begin
            int g = 0;
            while (!(busy_out && !cpu_reset_out && cycle_count_out == CW'(5)) && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                total++; bad++;
                $display("FAIL reach_count5 actual=%0d required=5", cycle_count_out);
            end
        end
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        wait_end();
        check("post_rst_cpu_reset", 32'(cpu_reset_out), 32'd1);

        // Reload after reset with back-pressure: program rewritten from address 0.
        pw[0] = 16'h2003; pw[1] = 16'h0000;
        run_test(2, 1'b1, 1'b1, 0, 0, 0, mk_end(1'b1, 1'b0, 1'b0, 1, 2));

        repeat (3) @(negedge clk);
        if (wr_q.size() != 0) begin
            total++; bad++;
            $display("FAIL pending_writes actual=%0d required=0", wr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
